// File: rtl/fft_sched_pkg.sv
// Shared types for the FFT stage scheduler: FSM state encoding and the
// per-pair address bundle produced by the address generator.
package fft_sched_pkg;

   localparam int STATE_W    = 3;
   localparam int ADDR_W_MAX = 16;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      LATCH = 3'd2,
      ISSUE = 3'd3,
      WAIT  = 3'd4,
      DONE  = 3'd5
   } state_t;

   // Fields are sized for the largest supported transform; users slice them.
   typedef struct packed {
      logic [ADDR_W_MAX-1:0] a;
      logic [ADDR_W_MAX-1:0] b;
      logic [ADDR_W_MAX-1:0] tw;
   } pair_addr_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Stage/pair counters for the in-place DIT FFT walk and the combinational
// operand (a, b) and twiddle addresses for the current pair.
module fft_addr_gen
   import fft_sched_pkg::*;
#(
   parameter int LOG_PTS = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       advance,
   output pair_addr_t addr,
   output logic       last
);

   logic [LOG_PTS-1:0] s;
   logic [LOG_PTS-2:0] j;
   logic [LOG_PTS-1:0] jx;
   logic [LOG_PTS-1:0] span;
   logic [LOG_PTS-1:0] mask;
   logic [LOG_PTS-1:0] a;
   logic [LOG_PTS-1:0] b;
   logic [LOG_PTS-1:0] shamt;
   logic [LOG_PTS-1:0] twf;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s <= '0;
         j <= '0;
      end else if (clear) begin
         s <= '0;
         j <= '0;
      end else if (advance) begin
         j <= j + (LOG_PTS-1)'(1);
         if (j == '1)
            s <= s + LOG_PTS'(1);
      end
   end

   assign last = (s == LOG_PTS'(LOG_PTS-1)) && (j == '1);

   always_comb begin
      jx    = {1'b0, j};
      span  = LOG_PTS'(1) << s;
      mask  = span - LOG_PTS'(1);
      a     = ((jx >> s) << (s + LOG_PTS'(1))) | (jx & mask);
      b     = a | span;
      shamt = LOG_PTS'(LOG_PTS-1) - s;
      twf   = (jx & mask) << shamt;
      addr    = '0;
      addr.a  = ADDR_W_MAX'(a);
      addr.b  = ADDR_W_MAX'(b);
      addr.tw = ADDR_W_MAX'(twf);
   end

endmodule

// File: rtl/fft_stage_scheduler.sv
// Sequencer driving one shared radix-2 butterfly over an external sample RAM
// and twiddle ROM. Optional cycle counter: FFT_SCHED_CYCLE_COUNT_EN.
//
// Handshakes: a transfer happens on a rising edge where val and rdy are both
// high; a val, once raised, is held with stable payload until that edge.
module fft_stage_scheduler
   import fft_sched_pkg::*;
#(
   parameter int n       = 32,
   parameter int LOG_PTS = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start_val,
   output logic               start_rdy,
   output logic               done_val,
   input  logic               done_rdy,
   output logic               rd_en,
   output logic [LOG_PTS-1:0] rd_addr_a,
   output logic [LOG_PTS-1:0] rd_addr_b,
   input  logic [n-1:0]       rd_ar,
   input  logic [n-1:0]       rd_ac,
   input  logic [n-1:0]       rd_br,
   input  logic [n-1:0]       rd_bc,
   output logic [LOG_PTS-2:0] tw_addr,
   input  logic [n-1:0]       tw_wr,
   input  logic [n-1:0]       tw_wc,
   output logic               bf_recv_val,
   input  logic               bf_recv_rdy,
   output logic [n-1:0]       bf_ar,
   output logic [n-1:0]       bf_ac,
   output logic [n-1:0]       bf_br,
   output logic [n-1:0]       bf_bc,
   output logic [n-1:0]       bf_wr,
   output logic [n-1:0]       bf_wc,
   input  logic               bf_send_val,
   output logic               bf_send_rdy,
   input  logic [n-1:0]       bf_cr,
   input  logic [n-1:0]       bf_cc,
   input  logic [n-1:0]       bf_dr,
   input  logic [n-1:0]       bf_dc,
   output logic               wr_en,
   output logic [LOG_PTS-1:0] wr_addr_a,
   output logic [LOG_PTS-1:0] wr_addr_b,
   output logic [n-1:0]       wr_ar,
   output logic [n-1:0]       wr_ac,
   output logic [n-1:0]       wr_br,
   output logic [n-1:0]       wr_bc,
`ifdef FFT_SCHED_CYCLE_COUNT_EN
   output logic [31:0]        cycle_count,
`endif
   output logic [STATE_W-1:0] state_dbg
);

   state_t     state;
   pair_addr_t pa;
   logic       last;
   logic       start_acc;
   logic       unused_addr_bits;

   assign start_acc = (state == IDLE) && start_val;
   assign wr_en     = (state == WAIT) && bf_send_val;
   assign state_dbg = state;

   fft_addr_gen #(.LOG_PTS(LOG_PTS)) u_addr_gen (
      .clk     (clk),
      .reset   (reset),
      .clear   (start_acc),
      .advance (wr_en),
      .addr    (pa),
      .last    (last)
   );

   // Address and write-data buses read as zero whenever their strobe is low.
   assign rd_addr_a = rd_en ? pa.a[LOG_PTS-1:0]  : '0;
   assign rd_addr_b = rd_en ? pa.b[LOG_PTS-1:0]  : '0;
   assign tw_addr   = rd_en ? pa.tw[LOG_PTS-2:0] : '0;
   assign wr_ar     = wr_en ? bf_cr : '0;
   assign wr_ac     = wr_en ? bf_cc : '0;
   assign wr_br     = wr_en ? bf_dr : '0;
   assign wr_bc     = wr_en ? bf_dc : '0;

   assign unused_addr_bits = ^{pa.a[ADDR_W_MAX-1:LOG_PTS], pa.b[ADDR_W_MAX-1:LOG_PTS],
                               pa.tw[ADDR_W_MAX-1:LOG_PTS-1]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         start_rdy   <= 1'b1;
         done_val    <= 1'b0;
         rd_en       <= 1'b0;
         bf_recv_val <= 1'b0;
         bf_send_rdy <= 1'b0;
         bf_ar       <= '0;
         bf_ac       <= '0;
         bf_br       <= '0;
         bf_bc       <= '0;
         bf_wr       <= '0;
         bf_wc       <= '0;
         wr_addr_a   <= '0;
         wr_addr_b   <= '0;
      end else begin
         case (state)
            IDLE: if (start_val) begin
               start_rdy <= 1'b0;
               rd_en     <= 1'b1;
               state     <= READ;
            end
            READ: begin
               rd_en <= 1'b0;
               state <= LATCH;
            end
            LATCH: begin
               bf_ar       <= rd_ar;
               bf_ac       <= rd_ac;
               bf_br       <= rd_br;
               bf_bc       <= rd_bc;
               bf_wr       <= tw_wr;
               bf_wc       <= tw_wc;
               wr_addr_a   <= pa.a[LOG_PTS-1:0];
               wr_addr_b   <= pa.b[LOG_PTS-1:0];
               bf_recv_val <= 1'b1;
               state       <= ISSUE;
            end
            ISSUE: if (bf_recv_rdy) begin
               bf_recv_val <= 1'b0;
               bf_send_rdy <= 1'b1;
               state       <= WAIT;
            end
            WAIT: if (bf_send_val) begin
               bf_send_rdy <= 1'b0;
               if (last) begin
                  done_val <= 1'b1;
                  state    <= DONE;
               end else begin
                  rd_en <= 1'b1;
                  state <= READ;
               end
            end
            DONE: if (done_rdy) begin
               done_val  <= 1'b0;
               start_rdy <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FFT_SCHED_CYCLE_COUNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cycle_count <= '0;
      else if (start_acc)
         cycle_count <= '0;
      else if ((state != IDLE) && (state != DONE) && (cycle_count != '1))
         cycle_count <= cycle_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Bench for fft_stage_scheduler: behavioural RAM/ROM, 1-cycle butterfly,
// textbook-loop reference FFT and expected address queue.
module tb_fft_stage_scheduler;
   import fft_sched_pkg::*;

   localparam int LP = 3;
   localparam int P  = 8;
   localparam int EW = 3*LP - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          start_val, start_rdy, done_val, done_rdy;
   logic          rd_en;
   logic [LP-1:0] rd_addr_a, rd_addr_b;
   logic [31:0]   rd_ar, rd_ac, rd_br, rd_bc;
   logic [LP-2:0] tw_addr;
   logic [31:0]   tw_wr, tw_wc;
   logic          bf_recv_val, bf_recv_rdy;
   logic [31:0]   bf_ar, bf_ac, bf_br, bf_bc, bf_wr, bf_wc;
   logic          bf_send_val, bf_send_rdy;
   logic [31:0]   bf_cr, bf_cc, bf_dr, bf_dc;
   logic          wr_en;
   logic [LP-1:0] wr_addr_a, wr_addr_b;
   logic [31:0]   wr_ar, wr_ac, wr_br, wr_bc;
   logic [STATE_W-1:0] state_dbg;
`ifdef FFT_SCHED_CYCLE_COUNT_EN
   logic [31:0]   cycle_count;
`endif

   fft_stage_scheduler #(.n(32), .LOG_PTS(LP)) dut (
      .clk(clk), .reset(reset),
      .start_val(start_val), .start_rdy(start_rdy),
      .done_val(done_val), .done_rdy(done_rdy),
      .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_ar(rd_ar), .rd_ac(rd_ac), .rd_br(rd_br), .rd_bc(rd_bc),
      .tw_addr(tw_addr), .tw_wr(tw_wr), .tw_wc(tw_wc),
      .bf_recv_val(bf_recv_val), .bf_recv_rdy(bf_recv_rdy),
      .bf_ar(bf_ar), .bf_ac(bf_ac), .bf_br(bf_br), .bf_bc(bf_bc),
      .bf_wr(bf_wr), .bf_wc(bf_wc),
      .bf_send_val(bf_send_val), .bf_send_rdy(bf_send_rdy),
      .bf_cr(bf_cr), .bf_cc(bf_cc), .bf_dr(bf_dr), .bf_dc(bf_dc),
      .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
      .wr_ar(wr_ar), .wr_ac(wr_ac), .wr_br(wr_br), .wr_bc(wr_bc),
`ifdef FFT_SCHED_CYCLE_COUNT_EN
      .cycle_count(cycle_count),
`endif
      .state_dbg(state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [EW-1:0] exp_q[$];
   logic [31:0]   init_r[P], init_i[P];
   logic [31:0]   ref_r[P], ref_i[P];
   logic [31:0]   mem_r[P], mem_i[P];
   logic [31:0]   rom_r[P/2], rom_i[P/2];
   logic          load;
   logic [LP-1:0] last_a, last_b;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Fixed-point (16 fractional bits) complex butterfly: c = a + w*b, d = a - w*b.
   function automatic void bfly(input logic [31:0] ar, ac, br, bc, wr, wc,
                                output logic [31:0] cr, cc, dr, dc);
      longint pr, pi;
      pr = (longint'($signed(wr)) * longint'($signed(br))
            - longint'($signed(wc)) * longint'($signed(bc))) >>> 16;
      pi = (longint'($signed(wr)) * longint'($signed(bc))
            + longint'($signed(wc)) * longint'($signed(br))) >>> 16;
      cr = ar + pr[31:0];
      cc = ac + pi[31:0];
      dr = ar - pr[31:0];
      dc = ac - pi[31:0];
   endfunction

   // ---------------- environment models ----------------
   initial begin
      rom_r[0] = 32'h0001_0000; rom_i[0] = 32'h0000_0000;
      rom_r[1] = 32'h0000_B505; rom_i[1] = 32'hFFFF_4AFB;
      rom_r[2] = 32'h0000_0000; rom_i[2] = 32'hFFFF_0000;
      rom_r[3] = 32'hFFFF_4AFB; rom_i[3] = 32'hFFFF_4AFB;
   end

   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < P; i++) begin
            mem_r[i] <= init_r[i];
            mem_i[i] <= init_i[i];
         end
      end else if (wr_en) begin
         mem_r[wr_addr_a] <= wr_ar;
         mem_i[wr_addr_a] <= wr_ac;
         mem_r[wr_addr_b] <= wr_br;
         mem_i[wr_addr_b] <= wr_bc;
      end
      if (rd_en) begin
         rd_ar <= mem_r[rd_addr_a];
         rd_ac <= mem_i[rd_addr_a];
         rd_br <= mem_r[rd_addr_b];
         rd_bc <= mem_i[rd_addr_b];
         tw_wr <= rom_r[tw_addr];
         tw_wc <= rom_i[tw_addr];
      end
   end

   logic [31:0] c_cr, c_cc, c_dr, c_dc;
   always_comb bfly(bf_ar, bf_ac, bf_br, bf_bc, bf_wr, bf_wc, c_cr, c_cc, c_dr, c_dc);

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         bf_send_val <= 1'b0;
         bf_cr <= '0; bf_cc <= '0; bf_dr <= '0; bf_dc <= '0;
      end else if (bf_recv_val && bf_recv_rdy) begin
         bf_send_val <= 1'b1;
         bf_cr <= c_cr; bf_cc <= c_cc; bf_dr <= c_dr; bf_dc <= c_dc;
      end else if (bf_send_val && bf_send_rdy) begin
         bf_send_val <= 1'b0;
      end
   end

   // ---------------- address monitor ----------------
   initial begin
      logic [EW-1:0] e;
      forever begin
         @(negedge clk);
         if (reset && rd_en) begin
            if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("rd_addr_a", rd_addr_a, e[EW-1 -: LP]);
               check("rd_addr_b", rd_addr_b, e[LP+LP-2 -: LP]);
               check("tw_addr", tw_addr, e[LP-2:0]);
               last_a = rd_addr_a;
               last_b = rd_addr_b;
            end
         end
         if (reset && wr_en) begin
            check("wr_addr_a", wr_addr_a, last_a);
            check("wr_addr_b", wr_addr_b, last_b);
         end
      end
   end

   // ---------------- reference model (textbook group/offset loops) ----------------
   task automatic build_reference();
      logic [31:0] cr, cc, dr, dc;
      logic [LP-1:0] ea, eb;
      logic [LP-2:0] et;
      int a, b, t, span;
      for (int i = 0; i < P; i++) begin
         ref_r[i] = init_r[i];
         ref_i[i] = init_i[i];
      end
      for (int s = 0; s < LP; s++) begin
         span = 1 << s;
         for (int g = 0; g < P; g += 2*span) begin
            for (int k = 0; k < span; k++) begin
               a = g + k;
               b = a + span;
               t = k * (P / (2*span));
               bfly(ref_r[a], ref_i[a], ref_r[b], ref_i[b], rom_r[t], rom_i[t], cr, cc, dr, dc);
               ref_r[a] = cr; ref_i[a] = cc;
               ref_r[b] = dr; ref_i[b] = dc;
            end
         end
      end
      // DIT issue order: within a stage, pairs go in increasing j = group*span + k
      for (int s = 0; s < LP; s++) begin
         span = 1 << s;
         for (int g = 0; g < P; g += 2*span) begin
            for (int k = 0; k < span; k++) begin
               ea = LP'(g + k);
               eb = LP'(g + k + span);
               et = (LP-1)'(k * (P / (2*span)));
               exp_q.push_back({ea, eb, et});
            end
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic load_ram();
      @(posedge clk); #1 load = 1'b1;
      @(posedge clk); #1 load = 1'b0;
   endtask

   task automatic randomize_data();
      for (int i = 0; i < P; i++) begin
         init_r[i] = $urandom_range(0, 32'h0003_0000) - 32'h0001_8000;
         init_i[i] = $urandom_range(0, 32'h0003_0000) - 32'h0001_8000;
      end
   endtask

   task automatic start_run();
      @(posedge clk); #1 start_val = 1'b1;
      @(posedge clk); #1 start_val = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      @(negedge clk);
      while (!done_val && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (!done_val) check("done_timeout", 0, 1);
   endtask

   task automatic release_done();
      done_rdy = 1'b1;
      @(posedge clk); #1 done_rdy = 1'b0;
   endtask

   task automatic check_results(input string tag);
      for (int i = 0; i < P; i++) begin
         check({tag, "_re"}, mem_r[i], ref_r[i]);
         check({tag, "_im"}, mem_i[i], ref_i[i]);
      end
      check({tag, "_pairs_left"}, exp_q.size(), 0);
   endtask

   // ---------------- directed sequence ----------------
   logic [31:0] o_ar, o_br, o_wr, c0;
   int          k;

   initial begin
      reset = 1'b0; start_val = 1'b0; done_rdy = 1'b0; bf_recv_rdy = 1'b1; load = 1'b0;
      last_a = '0; last_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_start_rdy", start_rdy, 1);
      check("rst_rd_en", rd_en, 0);
      check("rst_recv_val", bf_recv_val, 0);
      check("rst_send_rdy", bf_send_rdy, 0);
      check("rst_done_val", done_val, 0);
      check("rst_rd_addr_b", rd_addr_b, 0);
      check("rst_bf_wr", bf_wr, 0);
`ifdef FFT_SCHED_CYCLE_COUNT_EN
      check("rst_cycle_count", cycle_count, 0);
`endif
      @(posedge clk); #1 reset = 1'b1;

      // Run 1: impulse
      for (int i = 0; i < P; i++) begin
         init_r[i] = (i == 0) ? 32'h0001_0000 : 32'h0;
         init_i[i] = 32'h0;
      end
      load_ram();
      build_reference();
      start_run();
      wait_done(400);
      for (int i = 0; i < P; i++) begin
         check("impulse_re", mem_r[i], 32'h0001_0000);
         check("impulse_im", mem_i[i], 32'h0);
      end
      check("impulse_pairs_left", exp_q.size(), 0);
`ifdef FFT_SCHED_CYCLE_COUNT_EN
      check("impulse_cycles", cycle_count, 48);
`endif
      // Done hold with an ignored start request
      start_val = 1'b1;
      repeat (3) begin
         @(posedge clk); @(negedge clk);
         check("hold_done_val", done_val, 1);
         check("hold_start_rdy", start_rdy, 0);
         check("hold_rd_en", rd_en, 0);
      end
      start_val = 1'b0;
      done_rdy  = 1'b1;
      @(posedge clk); #1 done_rdy = 1'b0;
      @(negedge clk);
      check("release_start_rdy", start_rdy, 1);
      check("release_done_val", done_val, 0);
      check("release_state", state_dbg, IDLE);

      // Run 2: random data with butterfly backpressure on the first pair
      randomize_data();
      load_ram();
      build_reference();
      bf_recv_rdy = 1'b0;
      start_run();
      k = 0;
      @(negedge clk);
      while (!bf_recv_val && k < 50) begin @(negedge clk); k++; end
      check("bp_recv_val_seen", bf_recv_val, 1);
      check("bp_first_ar", bf_ar, init_r[0]);
      check("bp_first_br", bf_br, init_r[1]);
      check("bp_first_wr", bf_wr, 32'h0001_0000);
      o_ar = init_r[0]; o_br = init_r[1]; o_wr = 32'h0001_0000;
`ifdef FFT_SCHED_CYCLE_COUNT_EN
      c0 = cycle_count;
`else
      c0 = 0;
`endif
      repeat (5) begin
         @(negedge clk);
         check("bp_recv_val", bf_recv_val, 1);
         check("bp_ar_stable", bf_ar, o_ar);
         check("bp_br_stable", bf_br, o_br);
         check("bp_wr_stable", bf_wr, o_wr);
         check("bp_no_rd", rd_en, 0);
         check("bp_no_wr", wr_en, 0);
      end
`ifdef FFT_SCHED_CYCLE_COUNT_EN
      check("bp_cycles_grow", cycle_count, c0 + 32'd5);
`endif
      bf_recv_rdy = 1'b1;
      wait_done(400);
      check_results("rand_bp");
`ifdef FFT_SCHED_CYCLE_COUNT_EN
      check("bp_total_cycles", cycle_count, 53);
`endif
      release_done();

      // Run 3: abort during stage 1, pair j=2 (a=4, b=6), then a clean rerun
      randomize_data();
      load_ram();
      build_reference();
      start_run();
      k = 0;
      @(negedge clk);
      while (!(rd_en && rd_addr_a == 3'd4 && rd_addr_b == 3'd6) && k < 200) begin
         @(negedge clk); k++;
      end
      check("abort_point_seen", rd_addr_b, 3'd6);
      #2 reset = 1'b0;
      #1;
      check("abort_start_rdy", start_rdy, 1);
      check("abort_rd_en", rd_en, 0);
      check("abort_rd_addr_a", rd_addr_a, 0);
      check("abort_recv_val", bf_recv_val, 0);
      check("abort_send_rdy", bf_send_rdy, 0);
      check("abort_done_val", done_val, 0);
      check("abort_wr_en", wr_en, 0);
      check("abort_bf_ar", bf_ar, 0);
`ifdef FFT_SCHED_CYCLE_COUNT_EN
      check("abort_cycle_count", cycle_count, 0);
`endif
      exp_q.delete();
      @(posedge clk); #1 reset = 1'b1;
      randomize_data();
      load_ram();
      build_reference();
      start_run();
      wait_done(400);
      check_results("rerun");
`ifdef FFT_SCHED_CYCLE_COUNT_EN
      check("rerun_cycles", cycle_count, 48);
`endif
      release_done();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fft_stage_scheduler.md
# fft_stage_scheduler

Sequencer for a single shared radix-2 butterfly unit that computes an in-place, decimation-in-time FFT over an external sample RAM and twiddle ROM. The block walks every stage and butterfly pair and reads operands and twiddles. It drives the butterfly through its val/rdy ports and writes results back to the same addresses. It sits between the sample/twiddle memories and one butterfly instance; input samples are stored in bit-reversed order.

## Interface
- `n`, default 32: sample/twiddle word width (real and imaginary parts each).
- `LOG_PTS`, default 3: log2 of the point count; P = 2^LOG_PTS; address width = LOG_PTS.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start_val` in 1, `start_rdy` out 1: start handshake.
- `done_val` out 1, `done_rdy` in 1: completion handshake.
- `rd_en` out 1, `rd_addr_a` / `rd_addr_b` out LOG_PTS: dual-port sample read.
- `rd_ar`, `rd_ac`, `rd_br`, `rd_bc` in n: read data, valid the cycle after `rd_en`.
- `tw_addr` out LOG_PTS-1: twiddle index, presented with `rd_en`.
- `tw_wr`, `tw_wc` in n: twiddle data, valid the cycle after `rd_en`.
- `bf_recv_val` out 1, `bf_recv_rdy` in 1: butterfly operand handshake.
- `bf_ar`, `bf_ac`, `bf_br`, `bf_bc`, `bf_wr`, `bf_wc` out n: butterfly operands.
- `bf_send_val` in 1, `bf_send_rdy` out 1: butterfly result handshake.
- `bf_cr`, `bf_cc`, `bf_dr`, `bf_dc` in n: butterfly results.
- `wr_en` out 1, `wr_addr_a` / `wr_addr_b` out LOG_PTS, `wr_ar`, `wr_ac`, `wr_br`, `wr_bc` out n: dual-port write-back.

## Operation
- Counters: stage s in 0..LOG_PTS-1 and pair index j in 0..P/2-1; span = 1<<s.
- Addresses: a = ((j>>s)<<(s+1)) | (j & (span-1)); b = a | span.
- Twiddle index: (j & (span-1)) << (LOG_PTS-1-s).
- FSM states: IDLE, READ, LATCH, ISSUE, WAIT, DONE.
- IDLE: `start_rdy`=1. On `start_val`, clear s and j, then go to READ.
- READ: `rd_en`=1 with the a, b and twiddle addresses. Always moves to LATCH.
- LATCH: capture `rd_*` and `tw_*` into operand registers, then go to ISSUE.
- ISSUE: `bf_recv_val`=1 with the registered operands, held stable. On `bf_recv_rdy`, go to WAIT.
- WAIT: `bf_send_rdy`=1. In the cycle `bf_send_val` is high:
  - `wr_en`=1 combinationally; `wr_*` data is passed through from `bf_c*`/`bf_d*`; write addresses are the registered a and b.
  - Advance j. On wrap, reset j to 0 and advance s.
  - After the last pair of the last stage, go to DONE; otherwise go to READ.
- DONE: `done_val`=1 until `done_rdy`, then go to IDLE.
- Only one butterfly is in flight at a time, so no RAW hazards exist between pairs.
- Handshake rules:
  - `start_val` outside IDLE is ignored.
  - `bf_recv_val` never drops before it is accepted.
  - Results arriving outside WAIT are not possible given the sequencing; `bf_send_rdy`=0 outside WAIT.
- Arithmetic: no arithmetic on data. Fixed-point format is the butterfly's concern.

## Timing
- Reset (asynchronous, low): state goes to IDLE; s, j and operand registers are 0.
- Reset values of all outputs: 0, except `start_rdy`=1.
- Reset mid-run aborts immediately. The next start restarts at s=0, j=0. RAM contents are undefined.
- The butterfly's own reset is tied externally.
- Per pair: 2 cycles (READ, LATCH), plus ISSUE cycles until accept, plus WAIT cycles until result.
- Minimum per pair: 4 cycles with a butterfly whose result is valid one cycle after accept.
- Full run: (LOG_PTS · P/2) pairs, then DONE. Minimum 48 cycles for P=8.
- `done_val` rises the cycle after the final write.

## Configuration
- `FFT_SCHED_CYCLE_COUNT_EN` defined:
  - Adds output `cycle_count`, 32 bits.
  - Cleared on start accept; increments every cycle in READ, LATCH, ISSUE or WAIT.
  - Held from DONE until the next start accept; saturates at all-ones; reset value 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Package `fft_sched_pkg`: state enum type, state-width localparam, and a `pair_addr_t` struct (a, b, tw).
- Sub-module `fft_addr_gen`:
  - Owns the s/j counters, with an advance input and a last-pair output.
  - Produces the a, b and twiddle addresses combinationally.
  - FSM and operand registers stay in the top module.

## Test plan
All scenarios use P=8, a behavioural RAM/ROM and a butterfly model with 1-cycle latency unless stated.
- Reset: assert `reset` low mid-cycle -> all outputs 0 and `start_rdy`=1 immediately, without waiting for a clock edge.
- Address sequence: one run -> pairs (a,b) and twiddle indices are:
  - stage 0: (0,1) (2,3) (4,5) (6,7), tw 0,0,0,0;
  - stage 1: (0,2) (1,3) (4,6) (5,7), tw 0,2,0,2;
  - stage 2: (0,4) (1,5) (2,6) (3,7), tw 0,1,2,3.
- Functional: impulse input x[0]=0x00010000 (1.0, d=16), others 0, real FFTVRTL-style butterfly -> all 8 outputs real 0x00010000, imaginary 0. With the counter enabled, `cycle_count`=48.
- Backpressure: hold `bf_recv_rdy` low 5 cycles in ISSUE -> `bf_recv_val`=1 and operands stable, no `rd_en` or `wr_en`; `cycle_count` grows by 5.
- Done hold: `done_rdy` low 3 cycles -> `done_val` held, `start_rdy`=0, `start_val` ignored. Release `done_rdy` -> IDLE the next cycle.
- Abort: reset during stage 1, j=2 -> outputs 0 at once; a new start issues (0,1) tw 0 first.
